// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: load-use and multi-cycle multiplier interlocks,
// taken-branch flushing, and tracking of the single in-flight multiply.
module hazard_detection_unit #(
  parameter int DATA_WIDTH  = 5,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] D_Rs1,
  input  logic [DATA_WIDTH-1:0] D_Rs2,
  input  logic                  D_UseRs1,
  input  logic                  D_UseRs2,
  input  logic [DATA_WIDTH-1:0] D_Rd,
  input  logic                  D_RegWrite,
  input  logic                  D_MulStart,
  input  logic [DATA_WIDTH-1:0] E_Rd,
  input  logic                  E_MemRead,
  input  logic                  E_BranchTaken,
  output logic                  PC_Stall,
  output logic                  FD_Stall,
  output logic                  FD_Flush,
  output logic                  DE_Flush,
  output logic                  Mul_Busy,
  output logic                  Mul_Done,
  output logic [DATA_WIDTH-1:0] Mul_Rd
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  logic [CNT_W-1:0]      mul_cnt;
  logic [DATA_WIDTH-1:0] mul_rd_q;
  logic                  load_use;
  logic                  mul_raw;
  logic                  mul_waw;
  logic                  mul_hazard;
  logic                  stall;
  logic                  mul_issue;

  assign Mul_Busy = (mul_cnt != '0);
  assign Mul_Done = (mul_cnt == CNT_W'(1));
  assign Mul_Rd   = mul_rd_q;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    load_use   = 1'b0;
    mul_raw    = 1'b0;
    mul_waw    = 1'b0;
    mul_hazard = 1'b0;

    if (E_MemRead && (E_Rd != '0))
      load_use = (D_UseRs1 && (D_Rs1 == E_Rd)) ||
                 (D_UseRs2 && (D_Rs2 == E_Rd));

    // Register 0 is hardwired, so a multiply targeting it never creates a dependency.
    if (mul_rd_q != '0) begin
      mul_raw = (D_UseRs1 && (D_Rs1 == mul_rd_q)) ||
                (D_UseRs2 && (D_Rs2 == mul_rd_q));
      mul_waw = (D_RegWrite || D_MulStart) && (D_Rd == mul_rd_q);
    end

    // In the completion cycle the result is forwarded from WB, so nothing waits.
    if (Mul_Busy && !Mul_Done)
      mul_hazard = mul_raw || mul_waw || D_MulStart;
  end

  assign stall     = (load_use || mul_hazard) && !E_BranchTaken;
  assign PC_Stall  = stall;
  assign FD_Stall  = stall;
  assign DE_Flush  = stall || E_BranchTaken;
  assign FD_Flush  = E_BranchTaken;
  assign mul_issue = D_MulStart && !stall && !E_BranchTaken;

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt  <= '0;
      mul_rd_q <= '0;
    end else if (mul_issue) begin
      mul_cnt  <= CNT_W'(MUL_LATENCY);
      mul_rd_q <= D_Rd;
    end else if (mul_cnt != '0) begin
      mul_cnt  <= mul_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit: a driver queues expected
// outputs per applied vector, and an independent monitor pops and compares.
module tb_hazard_detection_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic       use1;
    logic [4:0] rs2;
    logic       use2;
    logic [4:0] rd;
    logic       regwrite;
    logic       mulstart;
    logic [4:0] erd;
    logic       ememread;
    logic       ebranch;
  } in_t;

  typedef struct packed {
    logic       pc_stall;
    logic       fd_stall;
    logic       fd_flush;
    logic       de_flush;
    logic       busy;
    logic       done;
    logic [4:0] mul_rd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] D_Rs1, D_Rs2, D_Rd, E_Rd;
  logic       D_UseRs1, D_UseRs2, D_RegWrite, D_MulStart, E_MemRead, E_BranchTaken;
  logic       PC_Stall, FD_Stall, FD_Flush, DE_Flush, Mul_Busy, Mul_Done;
  logic [4:0] Mul_Rd;

  exp_t  sb_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.DATA_WIDTH(5), .MUL_LATENCY(3)) dut (
    .clk(clk), .rst(rst),
    .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .D_UseRs1(D_UseRs1), .D_UseRs2(D_UseRs2),
    .D_Rd(D_Rd), .D_RegWrite(D_RegWrite), .D_MulStart(D_MulStart),
    .E_Rd(E_Rd), .E_MemRead(E_MemRead), .E_BranchTaken(E_BranchTaken),
    .PC_Stall(PC_Stall), .FD_Stall(FD_Stall), .FD_Flush(FD_Flush), .DE_Flush(DE_Flush),
    .Mul_Busy(Mul_Busy), .Mul_Done(Mul_Done), .Mul_Rd(Mul_Rd)
  );

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got pcs=%b fds=%b fdf=%b def=%b busy=%b done=%b rd=%0d, want pcs=%b fds=%b fdf=%b def=%b busy=%b done=%b rd=%0d",
               name, act.pc_stall, act.fd_stall, act.fd_flush, act.de_flush, act.busy, act.done, act.mul_rd,
               exp.pc_stall, exp.fd_stall, exp.fd_flush, exp.de_flush, exp.busy, exp.done, exp.mul_rd);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, half a cycle after inputs settle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string n;
      e = sb_q.pop_front();
      n = name_q.pop_front();
      check(n, {PC_Stall, FD_Stall, FD_Flush, DE_Flush, Mul_Busy, Mul_Done, Mul_Rd}, e);
    end
  end

  function automatic in_t idle();
    return '0;
  endfunction

  function automatic exp_t ex(logic st, logic fdf, logic def, logic busy, logic done, logic [4:0] rd);
    return {st, st, fdf, def, busy, done, rd};
  endfunction

  task automatic drive(input in_t v);
    rst = v.rst; D_Rs1 = v.rs1; D_UseRs1 = v.use1; D_Rs2 = v.rs2; D_UseRs2 = v.use2;
    D_Rd = v.rd; D_RegWrite = v.regwrite; D_MulStart = v.mulstart;
    E_Rd = v.erd; E_MemRead = v.ememread; E_BranchTaken = v.ebranch;
  endtask

  task automatic step(input string name, input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    drive(v);
    sb_q.push_back(e);
    name_q.push_back(name);
  endtask

  function automatic in_t mul(logic [4:0] rd);
    in_t v = '0;
    v.mulstart = 1'b1;
    v.rd = rd;
    return v;
  endfunction

  function automatic in_t read1(logic [4:0] rs);
    in_t v = '0;
    v.use1 = 1'b1;
    v.rs1 = rs;
    return v;
  endfunction

  initial begin
    in_t v;
    v = idle();
    v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);

    // Reset state, and stall logic still live while reset is held
    step("reset_idle", v, ex(0, 0, 0, 0, 0, 0));
    v = read1(5); v.rst = 1'b1; v.ememread = 1'b1; v.erd = 5;
    step("reset_loaduse", v, ex(1, 0, 1, 0, 0, 0));

    // Load-use
    v = read1(5); v.ememread = 1'b1; v.erd = 5;
    step("loaduse_rs1", v, ex(1, 0, 1, 0, 0, 0));
    v.erd = 0; v.rs1 = 0;
    step("loaduse_x0", v, ex(0, 0, 0, 0, 0, 0));
    v = idle(); v.ememread = 1'b1; v.erd = 9; v.rs2 = 9; v.use2 = 1'b1;
    step("loaduse_rs2", v, ex(1, 0, 1, 0, 0, 0));
    v.use2 = 1'b0; v.rs1 = 9;
    step("loaduse_unused_src", v, ex(0, 0, 0, 0, 0, 0));
    v = idle(); v.erd = 9; v.rs1 = 9; v.use1 = 1'b1;
    step("not_a_load", v, ex(0, 0, 0, 0, 0, 0));

    // Multiply RAW
    step("raw_issue", mul(7), ex(0, 0, 0, 0, 0, 0));
    step("raw_t1", read1(7), ex(1, 0, 1, 1, 0, 7));
    step("raw_t2", read1(7), ex(1, 0, 1, 1, 0, 7));
    step("raw_t3_done", read1(7), ex(0, 0, 0, 1, 1, 7));
    step("raw_t4_hold", idle(), ex(0, 0, 0, 0, 0, 7));

    // Back-to-back multiplies
    step("b2b_issue1", mul(3), ex(0, 0, 0, 0, 0, 7));
    step("b2b_t1", mul(4), ex(1, 0, 1, 1, 0, 3));
    step("b2b_t2", mul(4), ex(1, 0, 1, 1, 0, 3));
    step("b2b_t3_issue2", mul(4), ex(0, 0, 0, 1, 1, 3));
    step("b2b_t4", idle(), ex(0, 0, 0, 1, 0, 4));
    step("b2b_t5", idle(), ex(0, 0, 0, 1, 0, 4));
    step("b2b_t6_done", idle(), ex(0, 0, 0, 1, 1, 4));
    step("b2b_t7", idle(), ex(0, 0, 0, 0, 0, 4));

    // WAW against the in-flight destination
    step("waw_issue", mul(10), ex(0, 0, 0, 0, 0, 4));
    v = idle(); v.regwrite = 1'b1; v.rd = 10;
    step("waw_same_rd", v, ex(1, 0, 1, 1, 0, 10));
    v.rd = 11; v.rs1 = 10;
    step("waw_other_rd", v, ex(0, 0, 0, 1, 0, 10));
    step("waw_done", idle(), ex(0, 0, 0, 1, 1, 10));

    // Branch priority over load-use and a new multiply
    v = mul(12); v.ebranch = 1'b1; v.ememread = 1'b1; v.erd = 5; v.rs1 = 5; v.use1 = 1'b1;
    step("branch_prio", v, ex(0, 1, 1, 0, 0, 10));
    step("branch_no_issue", idle(), ex(0, 0, 0, 0, 0, 10));

    // Branch while a multiply is in flight: it still completes
    step("brbusy_issue", mul(13), ex(0, 0, 0, 0, 0, 10));
    v = read1(13); v.ebranch = 1'b1;
    step("brbusy_branch", v, ex(0, 1, 1, 1, 0, 13));
    step("brbusy_t2", idle(), ex(0, 0, 0, 1, 0, 13));
    step("brbusy_done", idle(), ex(0, 0, 0, 1, 1, 13));
    step("brbusy_after", idle(), ex(0, 0, 0, 0, 0, 13));

    // Reset mid-multiply
    step("rstmul_issue", mul(14), ex(0, 0, 0, 0, 0, 13));
    v = idle(); v.rst = 1'b1;
    step("rstmul_t1", v, ex(0, 0, 0, 1, 0, 14));
    step("rstmul_t2", idle(), ex(0, 0, 0, 0, 0, 0));
    step("rstmul_t3", idle(), ex(0, 0, 0, 0, 0, 0));
    step("rstmul_t4", idle(), ex(0, 0, 0, 0, 0, 0));

    // Reset wins over a simultaneous issue
    v = mul(6); v.rst = 1'b1;
    step("rst_vs_issue", v, ex(0, 0, 0, 0, 0, 0));
    step("rst_vs_issue_after", idle(), ex(0, 0, 0, 0, 0, 0));

    // Zero-register multiply never creates RAW/WAW, only the structural hazard
    step("x0_issue", mul(0), ex(0, 0, 0, 0, 0, 0));
    v = read1(0); v.regwrite = 1'b1; v.rd = 0;
    step("x0_waw_raw", v, ex(0, 0, 0, 1, 0, 0));
    step("x0_second_mul", mul(0), ex(1, 0, 1, 1, 0, 0));
    step("x0_done", idle(), ex(0, 0, 0, 1, 1, 0));
    step("x0_after", idle(), ex(0, 0, 0, 0, 0, 0));

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary, want completion");
    $fatal(1);
  end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5: register index width.
REQ-002 SHALL have parameter MUL_LATENCY, default 3: multiplier cycles from issue to writeback; legal range 2..15.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port D_Rs1 / D_Rs2  input  DATA_WIDTH each: decode-stage source indices.
REQ-006 SHALL have port D_UseRs1 / D_UseRs2  input  1 each: decode instruction reads that source.
REQ-007 SHALL have port D_Rd  input  DATA_WIDTH: decode-stage destination index.
REQ-008 SHALL have port D_RegWrite  input  1: decode instruction writes D_Rd through the ALU path.
REQ-009 SHALL have port D_MulStart  input  1: decode instruction is a multiply.
REQ-010 SHALL have port E_Rd  input  DATA_WIDTH: execute-stage destination.
REQ-011 SHALL have port E_MemRead  input  1: execute-stage instruction is a load.
REQ-012 SHALL have port E_BranchTaken  input  1: branch or jump resolved taken in execute.
REQ-013 SHALL have port PC_Stall / FD_Stall  output  1 each: hold PC and the IF/ID register.
REQ-014 SHALL have port FD_Flush / DE_Flush  output  1 each: bubble the IF/ID and ID/EX registers.
REQ-015 SHALL have port Mul_Busy  output  1: multiply in flight.
REQ-016 SHALL have port Mul_Done  output  1: one-cycle pulse; multiply result is in WB. This drives the forwarding unit's W_RegMul.
REQ-017 SHALL have port Mul_Rd  output  DATA_WIDTH: in-flight multiply destination. This drives the forwarding unit's W_Rd_Mul.

Function
REQ-018 SHALL assert load_use when E_MemRead, E_Rd != 0, and E_Rd matches a used source. A source is used when D_UseRs1 with D_Rs1, or D_UseRs2 with D_Rs2.
REQ-019 SHALL assert mul_hazard when Mul_Busy and !Mul_Done, and any of the following holds:
- the decode instruction uses a source equal to a nonzero Mul_Rd (RAW);
- D_RegWrite or D_MulStart with D_Rd == Mul_Rd != 0 (WAW);
- D_MulStart (single multiplier).
REQ-020 SHALL set stall = (load_use | mul_hazard) & !E_BranchTaken, as combinational logic.
REQ-021 SHALL drive PC_Stall = FD_Stall = stall.
REQ-022 SHALL drive DE_Flush = stall | E_BranchTaken.
REQ-023 SHALL drive FD_Flush = E_BranchTaken.
REQ-024 SHALL make a taken branch override every stall: PC_Stall = 0, and both flushes = 1.
REQ-025 SHALL issue a multiply in a cycle when D_MulStart & !stall & !E_BranchTaken. A stalled or flushed multiply never issues.
REQ-026 On issue, SHALL load a down-counter (width $clog2(MUL_LATENCY+1)) with MUL_LATENCY and capture D_Rd into Mul_Rd at the clock edge.
REQ-027 SHALL decrement the counter by 1 each cycle while it is nonzero. An issue in the same cycle reloads it instead of decrementing.
REQ-028 SHALL drive Mul_Busy = (counter != 0).
REQ-029 SHALL drive Mul_Done = (counter == 1), so an issue at cycle t pulses Mul_Done at cycle t+MUL_LATENCY.
REQ-030 In the Mul_Done cycle, SHALL raise no mul_hazard, so a dependent instruction advances and receives the WB forward. A new multiply may issue in that cycle (back-to-back).
REQ-031 SHALL hold Mul_Rd after completion until the next issue.
REQ-032 SHALL never cause a hazard for register index 0.
REQ-033 SHALL let the in-flight multiply complete when E_BranchTaken occurs while Mul_Busy. The multiply issued before the branch and is architecturally valid.
REQ-034 SHALL keep all outputs combinational from inputs and state, with no registered output delay.

Reset
REQ-035 When rst is high at a clock edge, SHALL clear the counter and Mul_Rd to 0, regardless of any in-flight multiply or simultaneous issue.
REQ-036 During and after reset, SHALL hold Mul_Busy = Mul_Done = 0. All stall and flush outputs SHALL then depend only on the current inputs.

Verification
REQ-037 Load-use: E_MemRead=1, E_Rd=5, D_Rs1=5, D_UseRs1=1 -> PC_Stall=FD_Stall=DE_Flush=1 and FD_Flush=0 for one cycle. With E_Rd=0 -> all outputs 0.
REQ-038 Multiply RAW: MUL_LATENCY=3, issue mul to x7 at t0 with a dependent read of x7 in decode from t1 -> stall at t1 and t2. At t3: Mul_Done=1, Mul_Rd=7, stall=0.
REQ-039 Back-to-back multiply: second D_MulStart at t1 stalls until t3, issues at t3, and gives Mul_Done at t6 with the new Mul_Rd.
REQ-040 Branch priority: E_BranchTaken=1 together with a load-use condition and D_MulStart=1 -> PC_Stall=0, FD_Flush=DE_Flush=1, and the counter stays 0.
REQ-041 Reset mid-multiply: rst pulse at t1 after an issue at t0 -> Mul_Busy=0 from t2, Mul_Done never pulses, Mul_Rd=0.
REQ-042 Zero-register WAW: Mul_Rd=0 in flight, with D_RegWrite=1 and D_Rd=0 in decode -> no stall.
